sn_to_bn_decoder: RTL

//  Stochastic-to-binary decoder: the receive end of the fsm_mux bit-stream interface.
//  Per channel, counts the ones in a DIM-wide stochastic bit stream over one generation window.

---
 rtl/sn_to_bn_decoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sn_to_bn_decoder.sv
// Stochastic-to-binary decoder: counts ones per channel over one window.
// Emits the binary counts, the window length and a one-cycle valid pulse.
module sn_to_bn_decoder #(
  parameter int NUM_BIT = 8,
  parameter int DIM     = 3
) (
  input  logic                          i_clk_sn_dec,
  input  logic                          i_rst_n_sn_dec,
  input  logic                          i_clear,
  input  logic                          i_isgen,
  input  logic [DIM-1:0]                i_sn_bit,
  output logic [DIM-1:0][NUM_BIT-1:0]   o_x_bn,
  output logic [NUM_BIT:0]              o_len,
  output logic                          o_valid,
  output logic                          o_full,
  output logic                          o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [NUM_BIT:0] FULL_LEN = {1'b1, {NUM_BIT{1'b0}}};
  localparam logic [NUM_BIT:0] LEN_ONE  = {{NUM_BIT{1'b0}}, 1'b1};

  state_t                      state_q, state_d;
  logic [DIM-1:0][NUM_BIT-1:0] acc_q, acc_d, acc_inc;
  logic [NUM_BIT:0]            len_q, len_d, len_inc;
  logic [DIM-1:0][NUM_BIT-1:0] x_d;
  logic [NUM_BIT:0]            olen_d;
  logic                        valid_d, full_d;

  // Saturating per-channel increment and next window length.
  always_comb begin
    acc_inc = acc_q;
    for (int i = 0; i < DIM; i++) begin
      if (!(&acc_q[i]))
        acc_inc[i] = acc_q[i] + {{(NUM_BIT-1){1'b0}}, i_sn_bit[i]};
    end
    len_inc = len_q + LEN_ONE;
  end

  // Next-state, accumulator and completion logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    x_d     = o_x_bn;
    olen_d  = o_len;
    valid_d = 1'b0;
    full_d  = o_full;
    unique case (state_q)
      IDLE: begin
        if (i_isgen) begin
          state_d = ACC;
          for (int i = 0; i < DIM; i++)
            acc_d[i] = {{(NUM_BIT-1){1'b0}}, i_sn_bit[i]};
          len_d = LEN_ONE;
        end
      end
      ACC: begin
        if (i_isgen) begin
          acc_d = acc_inc;
          len_d = len_inc;
          if (len_inc == FULL_LEN) begin
            state_d = HOLD;
            x_d     = acc_inc;
            olen_d  = len_inc;
            valid_d = 1'b1;
            full_d  = 1'b1;
            acc_d   = '0;
            len_d   = '0;
          end
        end else begin
          state_d = IDLE;
          x_d     = acc_q;
          olen_d  = len_q;
          valid_d = 1'b1;
          full_d  = 1'b0;
          acc_d   = '0;
          len_d   = '0;
        end
      end
      HOLD: begin
        if (!i_isgen)
          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        len_d   = '0;
      end
    endcase
    // Abort wins over the window, but a completion this cycle stands.
    if (i_clear) begin
      state_d = IDLE;
      acc_d   = '0;
      len_d   = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk_sn_dec or negedge i_rst_n_sn_dec) begin
    if (!i_rst_n_sn_dec) begin
      state_q <= IDLE;
      acc_q   <= '0;
      len_q   <= '0;
      o_x_bn  <= '0;
      o_len   <= '0;
      o_valid <= 1'b0;
      o_full  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      o_x_bn  <= x_d;
      o_len   <= olen_d;
      o_valid <= valid_d;
      o_full  <= full_d;
    end
  end

  assign o_busy = (state_q == ACC) || (state_q == HOLD);

endmodule
